mem_port_arbiter: RTL and testbench

- Sequences a single-port, byte-wide unified memory shared by two requesters: instruction fetch (10-byte window per PC) and the memory stage (8-byte data read/write).
- Serialises multi-byte accesses byte by byte and assembles or scatters words MSB-first, so the first byte in memory is the most significant.
- Sits between the fetch/memory stages and the memory array; the fetch stage stalls until its ack.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Byte-serial arbiter for a shared single-port memory: instruction fetch vs. data read/write.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates the grant when both ports request together.
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned FETCH_BYTES = 10,
  parameter int unsigned DATA_BYTES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    f_req,
  input  logic [63:0]             f_addr,
  output logic [8*FETCH_BYTES-1:0] f_rdata,
  output logic                    f_ack,
  output logic                    f_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [63:0]             d_addr,
  input  logic [8*DATA_BYTES-1:0] d_wdata,
  output logic [8*DATA_BYTES-1:0] d_rdata,
  output logic                    d_ack,
  output logic                    d_err,
  output logic [63:0]             mem_addr,
  output logic                    mem_we,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  output logic                    busy
);

  localparam int unsigned FW = 8 * FETCH_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam logic [63:0] F_LIMIT = 64'(MEM_BYTES - FETCH_BYTES);
  localparam logic [63:0] D_LIMIT = 64'(MEM_BYTES - DATA_BYTES);
  localparam logic [7:0]  F_N = 8'(FETCH_BYTES);
  localparam logic [7:0]  D_N = 8'(DATA_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic          gnt_d;     // 1 = data port owns the current transaction
  logic          we_q;
  logic [7:0]    n_q;
  logic [7:0]    cnt;
  logic [FW-1:0] asm_q;
  logic [DW-1:0] wdata_q;
  logic [63:0]   addr_q;

  logic          grant_any;
  logic          grant_d;
  logic          oor;
  logic          last_byte;
  logic [FW-1:0] asm_next;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;   // 0 = fetch, 1 = data

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (state == S_IDLE && grant_any) begin
      last_grant <= grant_d;
    end
  end
`endif

  always_comb begin
    grant_any = f_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_d = d_req & (~f_req | ~last_grant);
`else
    grant_d = d_req;
`endif
    oor       = grant_d ? (d_addr > D_LIMIT) : (f_addr > F_LIMIT);
    last_byte = (cnt == n_q - 8'd1);
    asm_next  = {asm_q[FW-9:0], mem_rdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gnt_d   <= 1'b0;
      we_q    <= 1'b0;
      n_q     <= '0;
      cnt     <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      f_rdata <= '0;
      d_rdata <= '0;
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      f_err   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            gnt_d   <= grant_d;
            we_q    <= grant_d & d_we;
            n_q     <= grant_d ? D_N : F_N;
            cnt     <= '0;
            asm_q   <= '0;
            wdata_q <= d_wdata;
            if (oor) begin
              // Rejected before touching memory; mem_addr keeps its old value.
              state <= S_DONE;
              if (grant_d) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                f_ack   <= 1'b1;
                f_err   <= 1'b1;
                f_rdata <= '0;
              end
            end else begin
              state  <= S_XFER;
              addr_q <= grant_d ? d_addr : f_addr;
            end
          end
        end
        S_XFER: begin
          cnt     <= cnt + 8'd1;
          asm_q   <= asm_next;
          wdata_q <= {wdata_q[DW-9:0], 8'h00};
          if (last_byte) begin
            state <= S_DONE;
            if (gnt_d) begin
              d_ack <= 1'b1;
              if (!we_q) d_rdata <= asm_next[DW-1:0];
            end else begin
              f_ack   <= 1'b1;
              f_rdata <= asm_next;
            end
          end else begin
            addr_q <= addr_q + 64'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe is qualified by rst_n so a reset cycle never commits the in-flight byte.
  assign mem_we    = rst_n & (state == S_XFER) & we_q;
  assign mem_wdata = mem_we ? wdata_q[DW-1:DW-8] : 8'h00;
  assign mem_addr  = addr_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a transaction-level memory model.
module tb_mem_port_arbiter;
  localparam int unsigned MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic [79:0] f_rdata;
  logic        f_ack, f_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_ack, d_err;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  mem_port_arbiter #(.MEM_BYTES(MEMB), .FETCH_BYTES(10), .DATA_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] tbmem  [MEMB];
  logic [7:0] ref_mem[MEMB];

  assign mem_rdata = (mem_addr < 64'(MEMB)) ? tbmem[mem_addr[9:0]] : 8'h00;
  always @(posedge clk) if (mem_we && mem_addr < 64'(MEMB)) tbmem[mem_addr[9:0]] <= mem_wdata;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [79:0] rdata;
    int unsigned edge_no;
  } exp_t;
  typedef struct {
    logic [63:0] a;
    logic [7:0]  b;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned next_free = 0;
  logic [79:0] mf = '0;
  logic [63:0] md = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit mlast = 1'b0;
`endif

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: range rule, byte order, rdata hold rules, ack timing.
  task automatic model_txn(input bit is_d, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, input int unsigned s,
                           output int unsigned ack_edge);
    int unsigned n;
    bit          err;
    exp_t        e;
    logic [79:0] rd;
    int          a0;
    n  = is_d ? 8 : 10;
    rd = '0;
    err = !(addr < 64'(MEMB) && (64'(MEMB) - addr) >= 64'(n));
    ack_edge = err ? s : s + n;
    if (!err) begin
      a0 = int'(addr[15:0]);
      for (int i = 0; i < int'(n); i++) begin
        if (is_d && we) begin
          ref_mem[a0 + i] = wdata[8*(7-i) +: 8];
          wr_q.push_back('{a: addr + 64'(i), b: wdata[8*(7-i) +: 8]});
        end else begin
          rd = {rd[71:0], ref_mem[a0 + i]};
        end
      end
    end
    if (is_d) begin
      if (err) md = '0;
      else if (!we) md = rd[63:0];
      e.rdata = {16'h0, md};
    end else begin
      mf = err ? '0 : rd;
      e.rdata = mf;
    end
    e.is_d = is_d;
    e.err = err;
    e.edge_no = ack_edge;
    exp_q.push_back(e);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mlast = is_d;
`endif
  endtask

  task automatic wait_acks(input int n, input bit keep_f);
    int got = 0;
    int t = 0;
    bit f_pend = f_req;
    bit d_pend = d_req;
    while (got < n && t < 300) begin
      @(negedge clk);
      t++;
      if (f_ack) begin got++; f_pend = 1'b0; end
      if (d_ack) begin got++; d_pend = 1'b0; end
      @(posedge clk); #1;
      if (!d_pend) d_req = 1'b0;
      if (!f_pend && !keep_f) f_req = 1'b0;
    end
    chk("ack_timeout", 80'(got), 80'(n));
  endtask

  task automatic do_single(input bit is_d, input bit we, input logic [63:0] addr,
                           input logic [63:0] wdata, input bit keep_f);
    int unsigned s, a;
    s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    model_txn(is_d, we, addr, wdata, s, a);
    next_free = a + 2;
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      f_addr = addr; f_req = 1'b1;
    end
    wait_acks(1, keep_f);
  endtask

  task automatic do_both(input logic [63:0] fa, input bit we, input logic [63:0] da,
                         input logic [63:0] wdata);
    int unsigned s, a1, a2;
    bit first_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_d = (mlast == 1'b0);
`else
    first_d = 1'b1;
`endif
    s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    if (first_d) begin
      model_txn(1'b1, we, da, wdata, s, a1);
      model_txn(1'b0, 1'b0, fa, '0, a1 + 2, a2);
    end else begin
      model_txn(1'b0, 1'b0, fa, '0, s, a1);
      model_txn(1'b1, we, da, wdata, a1 + 2, a2);
    end
    next_free = a2 + 2;
    f_addr = fa; f_req = 1'b1;
    d_we = we; d_addr = da; d_wdata = wdata; d_req = 1'b1;
    wait_acks(2, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every ack, checks rdata hold and write byte stream.
  logic [79:0] held_f = '0;
  logic [63:0] held_d = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_f = '0;
      held_d = '0;
    end else begin
      if (f_ack || d_ack) begin
        if (f_ack && d_ack) chk("dual_ack", 80'(1), 80'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 80'(1), 80'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_port", 80'(d_ack), 80'(e.is_d));
          chk("ack_cycle", 80'(cyc), 80'(e.edge_no));
          if (e.is_d) begin
            chk("d_err", 80'(d_err), 80'(e.err));
            chk("d_rdata", {16'h0, d_rdata}, e.rdata);
            held_d = e.rdata[63:0];
          end else begin
            chk("f_err", 80'(f_err), 80'(e.err));
            chk("f_rdata", f_rdata, e.rdata);
            held_f = e.rdata;
          end
        end
      end
      if (!f_ack) chk("f_rdata_hold", f_rdata, held_f);
      if (!d_ack) chk("d_rdata_hold", {16'h0, d_rdata}, {16'h0, held_d});
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 80'(mem_addr), 80'(0));
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", 80'(mem_addr), 80'(w.a));
          chk("wr_data", 80'(mem_wdata), 80'(w.b));
        end
      end
    end
  end

  initial begin
    logic [63:0] ma;
    logic [7:0]  init_bytes [10];
    logic [63:0] ra, rb;
    int          kind;
    init_bytes = '{8'h60, 8'h23, 8'h10, 8'h10, 8'h10, 8'h25, 8'h04, 8'h10, 8'h10, 8'h10};
    for (int i = 0; i < int'(MEMB); i++) tbmem[i] = 8'($urandom());
    for (int i = 0; i < 10; i++) tbmem[32 + i] = init_bytes[i];
    for (int i = 0; i < int'(MEMB); i++) ref_mem[i] = tbmem[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_f_ack", 80'(f_ack), 80'(0));
    chk("rst_d_ack", 80'(d_ack), 80'(0));
    chk("rst_errs", 80'({f_err, d_err}), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_mem_we", 80'({mem_we, mem_wdata}), 80'(0));
    chk("rst_mem_addr", 80'(mem_addr), 80'(0));
    chk("rst_f_rdata", f_rdata, 80'(0));
    chk("rst_d_rdata", 80'(d_rdata), 80'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_single(1'b0, 1'b0, 64'd32, '0, 1'b0);
    chk("fetch32_value", f_rdata, 80'h6023_1010_1025_0410_1010);
    do_single(1'b1, 1'b1, 64'd100, 64'h0011223344556677, 1'b0);
    do_single(1'b1, 1'b0, 64'd100, '0, 1'b0);
    chk("readback100", 80'(d_rdata), 80'(64'h0011223344556677));
    do_both(64'd200, 1'b0, 64'd300, '0);
    do_both(64'd40, 1'b1, 64'd500, 64'hDEADBEEF_CAFEF00D);

    ma = mem_addr;
    do_single(1'b0, 1'b0, 64'd1015, '0, 1'b0);
    chk("err_no_addr_move", 80'(mem_addr), 80'(ma));
    do_single(1'b0, 1'b0, 64'd1014, '0, 1'b0);
    do_single(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0);
    do_single(1'b1, 1'b0, 64'd1017, '0, 1'b0);
    do_single(1'b1, 1'b1, 64'd1016, 64'h8877665544332211, 1'b0);
    do_single(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b0);

    do_single(1'b0, 1'b0, 64'd0, '0, 1'b1);
    do_single(1'b0, 1'b0, 64'd10, '0, 1'b0);

    // Reset during the 4th byte of a write to 100..107 (currently 00..77).
    for (int i = 0; i < 3; i++) begin
      ref_mem[100 + i] = 8'hA1 + 8'(i);
      wr_q.push_back('{a: 64'd100 + 64'(i), b: 8'hA1 + 8'(i)});
    end
    d_we = 1'b1; d_addr = 64'd100; d_wdata = 64'hA1A2A3A4A5A6A7A8; d_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", 80'(mem_we), 80'(0));
    @(negedge clk);
    chk("rst_mid_busy", 80'(busy), 80'(0));
    chk("rst_mid_ack", 80'({d_ack, mem_we}), 80'(0));
    chk("rst_mid_mem", {tbmem[100], tbmem[101], tbmem[102], tbmem[103], tbmem[104],
                        tbmem[105], tbmem[106], tbmem[107], 16'h0},
        {64'hA1A2A333_44556677, 16'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    md = '0; mf = '0; next_free = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mlast = 1'b0;
`endif
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) rb = {$urandom(), $urandom()};
        else if (r == 1) rb = 64'($urandom_range(1008, 1023));
        else rb = 64'($urandom_range(0, 1023));
        if (j == 0) ra = rb;
      end
      case (kind)
        0: do_single(1'b0, 1'b0, ra, '0, 1'b0);
        1: do_single(1'b1, 1'b0, ra, '0, 1'b0);
        2: do_single(1'b1, 1'b1, ra, {$urandom(), $urandom()}, 1'b0);
        default: do_both(ra, 1'($urandom_range(0, 1)), rb, {$urandom(), $urandom()});
      endcase
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 80'(exp_q.size()), 80'(0));
    chk("writes_drained", 80'(wr_q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
